// File: rtl/trng_reader.sv
// Raw-entropy collector: parity-folds the rnddata bus to one bit per clk, runs a
// repetition-count health test, packs bits MSB-first into OUT_W words and queues them.
`ifndef STR_LEN
`define STR_LEN 8
`endif

module trng_reader #(
  parameter int unsigned LEN     = `STR_LEN,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WARMUP  = 16,
  parameter int unsigned REP_MAX = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [LEN-1:0]   rnddata,
  input  logic             en,
  input  logic             clr,
  output logic [OUT_W-1:0] rdata,
  output logic             rvalid,
  input  logic             rready,
  output logic             fault,
  output logic             ovf
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(OUT_W);
  localparam int unsigned WW   = $clog2(WARMUP + 1);
  localparam logic [7:0]  REP_LIM = 8'(REP_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COLLECT,
    ST_FAULT
  } state_t;

  state_t state, state_nxt;

  logic [OUT_W-2:0] acc;
  logic [CW-1:0]    bit_cnt;
  logic [WW-1:0]    warm_cnt;
  logic [7:0]       rep_cnt;
  logic [7:0]       rep_nxt;
  logic             prev_bit;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count;

  logic             raw_bit, sampling, rep_hit, warm_done, word_done;
  logic             push_req, push_ok, pop, full, ovf_set;
  logic [OUT_W-1:0] acc_word;

  assign raw_bit   = ^rnddata;
  assign sampling  = en && (state == ST_WARMUP || state == ST_COLLECT);
  assign warm_done = (state == ST_WARMUP) && (warm_cnt == WW'(WARMUP - 1));
  assign word_done = (state == ST_COLLECT) && (bit_cnt == CW'(OUT_W - 1));
  assign acc_word  = {acc, raw_bit};

  // rep_cnt == 0 marks "no previous bit yet", so the first sample always starts a run of 1
  always_comb begin
    rep_nxt = 8'd1;
    if (rep_cnt != 8'd0 && raw_bit == prev_bit)
      rep_nxt = (rep_cnt == REP_LIM) ? REP_LIM : rep_cnt + 8'd1;
  end

  assign rep_hit  = sampling && (rep_nxt == REP_LIM);
  assign push_req = sampling && word_done && !rep_hit;
  assign full     = (count == CNTW'(DEPTH));
  assign pop      = rvalid && rready && (state != ST_FAULT);
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (en) state_nxt = ST_WARMUP;
      ST_WARMUP:  if (!en)            state_nxt = ST_IDLE;
                  else if (rep_hit)   state_nxt = ST_FAULT;
                  else if (warm_done) state_nxt = ST_COLLECT;
      ST_COLLECT: if (!en)            state_nxt = ST_IDLE;
                  else if (rep_hit)   state_nxt = ST_FAULT;
      ST_FAULT:   if (clr) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fault = (state == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      bit_cnt  <= '0;
      warm_cnt <= '0;
      rep_cnt  <= '0;
      prev_bit <= 1'b0;
    end else begin
      warm_cnt <= (state == ST_WARMUP && en) ? warm_cnt + WW'(1) : '0;
      rep_cnt  <= sampling ? rep_nxt : '0;
      if (sampling) prev_bit <= raw_bit;
      if (sampling && state == ST_COLLECT && !rep_hit) begin
        acc     <= acc_word[OUT_W-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      end else begin
        acc     <= '0;
        bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rep_hit) mem[wr_ptr] <= acc_word;
  end

  // A health-test hit flushes the queue and overrides any pop/push in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rep_hit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CNTW'(1);
      else if (pop && !push_ok) count <= count - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (clr)     ovf <= 1'b0;
  end

  assign rvalid = (count != '0);
  assign rdata  = rvalid ? mem[rd_ptr] : '0;

endmodule
